// File: rtl/neureka_column_serializer_if.sv
// Push/pop stream bundle of the column serializer: NB_COLS input columns, one output stream.
interface neureka_column_serializer_if #(
  parameter int unsigned NB_COLS    = 9,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned STRB_WIDTH = 32
);
  logic [NB_COLS*DATA_WIDTH-1:0] push_data_i;
  logic [NB_COLS*STRB_WIDTH-1:0] push_strb_i;
  logic [NB_COLS-1:0]            push_valid_i;
  logic [NB_COLS-1:0]            push_ready_o;
  logic [DATA_WIDTH-1:0]         pop_data_o;
  logic [STRB_WIDTH-1:0]         pop_strb_o;
  logic                          pop_valid_o;
  logic                          pop_ready_i;

  // Producer/consumer side (streamout ports and store_out sink)
  modport master (
    output push_data_i, push_strb_i, push_valid_i, pop_ready_i,
    input  push_ready_o, pop_data_o, pop_strb_o, pop_valid_o
  );

  // Serializer side
  modport slave (
    input  push_data_i, push_strb_i, push_valid_i, pop_ready_i,
    output push_ready_o, pop_data_o, pop_strb_o, pop_valid_o
  );
endinterface

// File: rtl/neureka_column_serializer.sv
// Merges NB_COLS column streams into one registered output stream, visiting the masked
// columns in ascending order with burst_len beats per visit for nb_rounds passes.
module neureka_column_serializer #(
  parameter int unsigned NB_COLS    = 9,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned STRB_WIDTH = 32,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned ROUNDS_W   = 16,
  localparam int unsigned ColW      = (NB_COLS > 1) ? $clog2(NB_COLS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [NB_COLS-1:0]   col_mask_i,
  input  logic [BURST_W-1:0]   burst_len_i,
  input  logic [ROUNDS_W-1:0]  nb_rounds_i,
  neureka_column_serializer_if.slave bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ColW-1:0]      cur_col_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [NB_COLS-1:0]    mask_q, mask_d;
  logic [BURST_W-1:0]    burst_q, burst_d, beat_q, beat_d;
  logic [ROUNDS_W-1:0]   rounds_q, rounds_d, round_q, round_d;
  logic [ColW-1:0]       col_q, col_d;
  logic                  pop_valid_q, pop_valid_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [STRB_WIDTH-1:0] pop_strb_q, pop_strb_d;

  logic            out_free, accept, above_found;
  logic [ColW-1:0] above_col, low_col, start_col;

  // Column search: next set bit above cur_col, lowest set bit of latched and incoming mask
  always_comb begin
    above_found = 1'b0;
    above_col   = '0;
    low_col     = '0;
    start_col   = '0;
    // Descending scan so the last hit is the lowest matching index
    for (int c = NB_COLS - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        low_col = ColW'(c);
        if (ColW'(c) > col_q) begin
          above_found = 1'b1;
          above_col   = ColW'(c);
        end
      end
      if (col_mask_i[c]) start_col = ColW'(c);
    end
  end

  // Handshake: only the selected column sees ready, and only when the output slot frees up
  always_comb begin
    out_free         = !pop_valid_q || bus.pop_ready_i;
    bus.push_ready_o = '0;
    for (int c = 0; c < NB_COLS; c++) begin
      bus.push_ready_o[c] = (state_q == StRun) && (ColW'(c) == col_q) && out_free;
    end
    accept = (state_q == StRun) && bus.push_valid_i[col_q] && out_free;
  end

  // Next-state: output register, sequencing counters and job FSM
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    burst_d     = burst_q;
    rounds_d    = rounds_q;
    beat_d      = beat_q;
    round_d     = round_q;
    col_d       = col_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    pop_strb_d  = pop_strb_q;
    done_o      = 1'b0;

    if (accept) begin
      pop_valid_d = 1'b1;
      pop_data_d  = bus.push_data_i[col_q*DATA_WIDTH +: DATA_WIDTH];
      pop_strb_d  = bus.push_strb_i[col_q*STRB_WIDTH +: STRB_WIDTH];
    end else if (bus.pop_ready_i) begin
      pop_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d   = col_mask_i;
          burst_d  = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
          rounds_d = nb_rounds_i;
          col_d    = start_col;
          beat_d   = '0;
          round_d  = '0;
          state_d  = (col_mask_i != '0 && nb_rounds_i != '0) ? StRun : StDrain;
        end
      end
      StRun: begin
        if (accept) begin
          if (beat_q == burst_q - 1'b1) begin
            beat_d = '0;
            if (above_found) begin
              col_d = above_col;
            end else begin
              // Wrap closes a round; a single-bit mask wraps on every visit
              col_d   = low_col;
              round_d = round_q + 1'b1;
              if (round_q == rounds_q - 1'b1) state_d = StDrain;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!pop_valid_q) begin
          state_d = StIdle;
          done_o  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft clear overrides everything, including the done pulse
    if (clear_i) begin
      state_d     = StIdle;
      mask_d      = '0;
      burst_d     = '0;
      rounds_d    = '0;
      beat_d      = '0;
      round_d     = '0;
      col_d       = '0;
      pop_valid_d = 1'b0;
      done_o      = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      burst_q     <= '0;
      rounds_q    <= '0;
      beat_q      <= '0;
      round_q     <= '0;
      col_q       <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      pop_strb_q  <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      burst_q     <= burst_d;
      rounds_q    <= rounds_d;
      beat_q      <= beat_d;
      round_q     <= round_d;
      col_q       <= col_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      pop_strb_q  <= pop_strb_d;
    end
  end

  assign bus.pop_valid_o = pop_valid_q;
  assign bus.pop_data_o  = pop_data_q;
  assign bus.pop_strb_o  = pop_strb_q;
  assign busy_o          = (state_q != StIdle);
  assign cur_col_o       = col_q;

endmodule

// File: tb/tb_neureka_column_serializer.sv
// Scoreboard bench for neureka_column_serializer: random column sources, random output
// back-pressure, expected beat order built from the mask/burst/round rules.
module tb_neureka_column_serializer;
  localparam int NB = 9;
  localparam int DW = 256;
  localparam int SW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [NB-1:0] col_mask_i = '0;
  logic [7:0]    burst_len_i = '0;
  logic [15:0]   nb_rounds_i = '0;
  logic          busy_o, done_o;
  logic [3:0]    cur_col_o;

  neureka_column_serializer_if #(.NB_COLS(NB), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  neureka_column_serializer #(
    .NB_COLS(NB), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .BURST_W(8), .ROUNDS_W(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .col_mask_i  (col_mask_i),
    .burst_len_i (burst_len_i),
    .nb_rounds_i (nb_rounds_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cur_col_o   (cur_col_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int chk = 0;
  int err = 0;

  logic [DW-1:0] src_data [NB][64];
  logic [SW-1:0] src_strb [NB][64];
  int            sent [NB];
  int            quota [NB];
  logic [NB-1:0] push_fire = '0;
  beat_t         exp_q [$];
  bit            drv_en = 1'b0;
  bit            toggle = 1'b0;
  int            valid_pct = 100;
  int            ready_pct = 100;
  int            pops = 0;
  int            last_pop_cyc = 0;
  int            start_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    chk++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // Column sources: present the next beat of each column, randomly gapped
  always @(negedge clk_i) begin
    if (drv_en) begin
      for (int c = 0; c < NB; c++) if (push_fire[c]) sent[c]++;
      for (int c = 0; c < NB; c++) begin
        bus.push_valid_i[c] = (sent[c] < quota[c]) && ($urandom_range(99) < valid_pct);
        bus.push_data_i[c*DW +: DW] = src_data[c][sent[c] & 63];
        bus.push_strb_i[c*SW +: SW] = src_strb[c][sent[c] & 63];
      end
      bus.pop_ready_i = toggle ? !bus.pop_ready_i : ($urandom_range(99) < ready_pct);
      #1;
      push_fire = bus.push_valid_i & bus.push_ready_o;
    end else begin
      push_fire = '0;
    end
  end

  // Monitor: any presented beat must equal the scoreboard head (also covers stall stability)
  always @(negedge clk_i) begin
    #2;
    if (bus.pop_valid_o) begin
      chk++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL unexpected_beat got=%0h exp=none", bus.pop_data_o);
      end else begin
        if (bus.pop_data_o !== exp_q[0].d || bus.pop_strb_o !== exp_q[0].s) begin
          err++;
          $display("FAIL beat%0d got=%0h/%0h exp=%0h/%0h", pops, bus.pop_data_o,
                   bus.pop_strb_o, exp_q[0].d, exp_q[0].s);
        end
        if (bus.pop_ready_i) begin
          void'(exp_q.pop_front());
          pops++;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  // Reference model: rounds x (ascending masked columns) x burst beats, each column in order
  task automatic start_job(input logic [NB-1:0] mask, input int burst, input int rounds,
                           input int vpct, input int rpct, input bit tog);
    int beff;
    exp_q.delete();
    pops = 0;
    for (int c = 0; c < NB; c++) begin
      sent[c]  = 0;
      quota[c] = 0;
      for (int k = 0; k < 64; k++) begin
        for (int w = 0; w < DW / 32; w++) src_data[c][k][w*32 +: 32] = $urandom();
        src_strb[c][k] = $urandom();
      end
    end
    beff = (burst == 0) ? 1 : burst;
    for (int r = 0; r < rounds; r++)
      for (int c = 0; c < NB; c++)
        if (mask[c])
          for (int b = 0; b < beff; b++) begin
            exp_q.push_back('{d: src_data[c][quota[c]], s: src_strb[c][quota[c]]});
            quota[c]++;
          end
    valid_pct = vpct;
    ready_pct = rpct;
    toggle    = tog;
    @(negedge clk_i);
    #4;
    col_mask_i  = mask;
    burst_len_i = 8'(burst);
    nb_rounds_i = 16'(rounds);
    start_i     = 1'b1;
    drv_en      = 1'b1;
    start_cyc   = cyc;
  endtask

  task automatic stop_drive();
    drv_en = 1'b0;
    bus.push_valid_i = '0;
    bus.pop_ready_i  = 1'b1;
  endtask

  task automatic run_job(input logic [NB-1:0] mask, input int burst, input int rounds,
                         input int vpct, input int rpct, input bit tog, input bit restart);
    int  dones = 0;
    int  done_cyc = 0;
    bit  any_ready = 1'b0;
    bit  nz;
    int  low = 0;
    nz = (mask != '0) && (rounds != 0);
    for (int c = NB - 1; c >= 0; c--) if (mask[c]) low = c;
    start_job(mask, burst, rounds, vpct, rpct, tog);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      #3;
      if (bus.push_ready_o != '0) any_ready = 1'b1;
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      if (i == 0) check("cur_col_at_start", 64'(cur_col_o), 64'(low));
      #1;
      if (i == 0 && restart) begin
        // A start while busy must not disturb the running job
        col_mask_i  = 9'h1FF;
        burst_len_i = 8'd5;
        nb_rounds_i = 16'd3;
        start_i     = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (dones > 0 && cyc >= done_cyc + 4) break;
    end
    stop_drive();
    if (dones == 0) begin
      chk++;
      err++;
      $display("FAIL job_timeout got=no_done exp=done");
      clear_i = 1'b1;
      @(negedge clk_i);
      #4;
      clear_i = 1'b0;
    end else begin
      check("done_once", 64'(dones), 64'd1);
      if (nz) check("done_after_last_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
      else begin
        check("done_after_start", 64'(done_cyc), 64'(start_cyc + 1));
        check("no_push_ready", 64'(any_ready), 64'd0);
      end
    end
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
  endtask

  task automatic clear_test();
    int  dones = 0;
    bit  reached = 1'b0;
    start_job(9'h1FF, 1, 1, 100, 100, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      #3;
      if (done_o) dones++;
      #1;
      start_i = 1'b0;
      if (pops >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("clear_reached_beat4", 64'(reached), 64'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    #3;
    check("clear_pop_valid", 64'(bus.pop_valid_o), 64'd0);
    check("clear_busy", 64'(busy_o), 64'd0);
    if (done_o) dones++;
    #1;
    clear_i = 1'b0;
    stop_drive();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #3;
      if (done_o) dones++;
    end
    check("clear_no_done", 64'(dones), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.push_data_i  = '0;
    bus.push_strb_i  = '0;
    bus.push_valid_i = '0;
    bus.pop_ready_i  = 1'b1;
    #23;
    check("rst_pop_valid", 64'(bus.pop_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cur_col", 64'(cur_col_o), 64'd0);
    check("rst_push_ready", 64'(bus.push_ready_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_job(9'h1FF, 1, 1, 100, 100, 1'b0, 1'b0);        // all columns once
    run_job(9'b100100101, 3, 2, 100, 100, 1'b0, 1'b0);  // sparse mask, bursts, two rounds
    run_job(9'h1FF, 1, 1, 60, 100, 1'b1, 1'b0);         // toggling ready, valid gaps
    run_job(9'h000, 1, 1, 100, 100, 1'b0, 1'b0);        // empty mask
    run_job(9'h1FF, 1, 0, 100, 100, 1'b0, 1'b0);        // zero rounds
    clear_test();
    run_job(9'h1FF, 1, 1, 100, 100, 1'b0, 1'b0);        // clean run after clear
    run_job(9'h003, 0, 1, 100, 100, 1'b0, 1'b1);        // burst 0, start while busy
    run_job(9'h010, 2, 3, 70, 70, 1'b0, 1'b0);          // single-bit mask
    for (int j = 0; j < 6; j++) begin
      run_job(NB'($urandom()), $urandom_range(4), $urandom_range(3),
              $urandom_range(40, 100), $urandom_range(40, 100), 1'b0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
